pipelined_carry_adder: RTL

- Parametrised N-bit ripple-carry adder/subtractor, pipelined.
- The carry chain is split into STAGES equal chunks. Each chunk is a ripple of full-adder cells, and one pipeline register sits between chunks.
- The block carries a valid/ready handshake on both sides with full backpressure.
- Datapath arithmetic primitive for accumulator and ALU blocks that need WIDTH beyond a single-cycle ripple at target clock.

---
 rtl/pipelined_carry_adder.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of CHUNK full-adder cells with valid/ready backpressure.
// Optional PCA_SATURATE_EN: clamp the sum on signed overflow in the final stage.
module pipelined_carry_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_err
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Rank 0 holds conditioned operands; rank k+1 holds the beat after chunk k has been added.
    logic [STAGES:0]   v_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;

    logic [WIDTH-1:0]  s_c [STAGES];
    logic [STAGES-1:0] c_c;
    logic [WIDTH-1:0]  sum_c;
    logic              ovf_c;
    logic              stall_c;

    assign stall_c   = out_valid && !out_ready;
    assign in_ready  = !stall_c;
    assign out_valid = v_q[STAGES];

    // Ripple each stage's chunk, starting from the carry it received.
    always_comb begin
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        s = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            c = c_q[k];
            s = s_q[k];
            for (int unsigned i = 0; i < CHUNK; i++) begin
                s[k*CHUNK+i] = a_q[k][k*CHUNK+i] ^ b_q[k][k*CHUNK+i] ^ c;
                c = (a_q[k][k*CHUNK+i] & b_q[k][k*CHUNK+i])
                  | (c & (a_q[k][k*CHUNK+i] ^ b_q[k][k*CHUNK+i]));
            end
            s_c[k] = s;
            c_c[k] = c;
        end
    end

    // Same-sign operands producing an opposite-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
    assign ovf_c = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                && (s_c[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

`ifdef PCA_SATURATE_EN
    // Overflow direction follows the sign of A, which is still present in the last rank.
    always_comb begin
        sum_c = s_c[LAST];
        if (ovf_c) begin
            sum_c = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_c = s_c[LAST];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            c_q  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall_c) begin
            v_q    <= {v_q[STAGES-1:0], in_valid};
            a_q[0] <= a;
            b_q[0] <= sub ? ~b : b;
            s_q[0] <= '0;
            c_q[0] <= sub | cin;
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_c[k-1];
                c_q[k] <= c_c[k-1];
            end
            // Result registers only move when a valid beat lands, so bubbles never disturb them.
            if (v_q[LAST]) begin
                sum  <= sum_c;
                cout <= c_c[LAST];
                ovf  <= ovf_c;
            end
        end
    end

endmodule
